mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have fetch side: fetch_request_enable in 1 (1-cycle pulse), freq_mode in 1 (1=write), freq_addr in 32, freq_wdata in 32, freq_wstrb in 4, fetch_response_enable out 1 (1-cycle pulse), fresp_data out 32.
REQ-004 SHALL have mem side, same shape: mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb (in); mem_response_enable, mresp_data (out).
REQ-005 SHALL have downstream (MMU) side: request_enable out 1 (pulse), req_mode out 1, req_addr out 32, req_wdata out 32, req_wstrb out 4, response_enable in 1 (pulse), resp_data in 32.
REQ-006 SHALL have no parameters; all widths fixed as above.

Function
REQ-007 SHALL latch each upstream request (mode, addr, wdata, wstrb) into a per-requester slot with a pending flag in the cycle its enable pulse is sampled.
REQ-008 SHALL ignore an upstream pulse whose requester is already pending or in flight; the latched payload SHALL remain unchanged.
REQ-009 SHALL run FSM IDLE -> WAIT -> IDLE; only one downstream transaction outstanding at any time.
REQ-010 IDLE: if any requester is eligible (pending flag or pulse this cycle), SHALL grant one, register its payload onto req_* and assert request_enable for exactly the next cycle, enter WAIT.
REQ-011 Latency: upstream pulse in cycle N with arbiter IDLE -> request_enable high in cycle N+1.
REQ-012 WAIT: req_* SHALL hold the granted payload stable until response_enable.
REQ-013 On response_enable in cycle M (WAIT): resp_data SHALL be registered to the owner's resp data port, owner's response_enable pulsed in cycle M+1, owner's pending cleared, FSM -> IDLE at M+1.
REQ-014 Non-owner response enable and data output SHALL not change on a response; fresp_data/mresp_data hold last delivered value.
REQ-015 Back-to-back: with the other requester pending, next request_enable SHALL occur at M+2.
REQ-016 Owner MAY re-request in cycle M+1; that pulse SHALL be accepted.
REQ-017 Tie (both eligible in same IDLE cycle): default fixed priority, mem wins; loser stays pending.
REQ-018 response_enable while IDLE SHALL be ignored (no upstream pulse, no state change).
REQ-019 request_enable SHALL never be high two consecutive cycles.

Reset
REQ-020 While rst high at a clock edge: FSM=IDLE, both pending flags=0, request_enable=0, fetch_response_enable=0, mem_response_enable=0, req_mode=0, req_addr=0, req_wdata=0, req_wstrb=0, fresp_data=0, mresp_data=0, round-robin pointer=fetch-last.
REQ-021 Reset mid-transaction SHALL abandon it; a response_enable arriving after reset deasserts SHALL be ignored per REQ-018.
REQ-022 Upstream pulses sampled in the same cycle as rst high SHALL be discarded.

Configuration
REQ-023 Macro MEM_ARBITER_RR_EN: when defined, ties SHALL go to the requester not granted most recently (pointer updated on every grant; after reset mem wins first tie); when undefined, fixed mem priority per REQ-017 and no pointer register exists.

Verification
REQ-024 Fetch read: fetch pulse addr=0x0000_1000 mode=0 at cycle 10 -> request_enable at 11 with req_addr=0x1000; response_enable at 15 resp_data=0xDEAD_BEEF -> fetch_response_enable at 16, fresp_data=0xDEADBEEF, mem_response_enable stays 0.
REQ-025 Tie: fetch addr=0x100 and mem write addr=0x200 wdata=0x1234_5678 wstrb=0xF both at cycle 5 -> mem issued at 6; response at 9 -> mem_response_enable at 10; fetch issued at 11 (req_addr=0x100).
REQ-026 Duplicate: mem pulse addr=0x300 at 5, second mem pulse addr=0x400 at 7 (in flight) -> only 0x300 issued, no second downstream request after response.
REQ-027 Reset mid-op: fetch issued at 6, rst high at 8, response_enable at 10 -> no fetch_response_enable, all outputs 0, next fetch pulse at 12 issues at 13.
REQ-028 With MEM_ARBITER_RR_EN: three consecutive ties -> grant order mem, fetch, mem; without macro -> mem each time first.
REQ-029 Spurious response_enable in IDLE with resp_data=0xFFFF_FFFF -> no response pulses, fresp_data/mresp_data unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, mem and downstream MMU request/response signals.
// The arbiter takes the slave view, the environment drives the master view.
interface mem_arbiter_if;
  logic        fetch_request_enable;
  logic        freq_mode;
  logic [31:0] freq_addr;
  logic [31:0] freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;

  logic        mem_request_enable;
  logic        mreq_mode;
  logic [31:0] mreq_addr;
  logic [31:0] mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;

  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;

  modport slave (
    input  fetch_request_enable, freq_mode,
    input  freq_addr, freq_wdata, freq_wstrb,
    output fetch_response_enable, fresp_data,
    input  mem_request_enable, mreq_mode,
    input  mreq_addr, mreq_wdata, mreq_wstrb,
    output mem_response_enable, mresp_data,
    output request_enable, req_mode,
    output req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data
  );

  modport master (
    output fetch_request_enable, freq_mode,
    output freq_addr, freq_wdata, freq_wstrb,
    input  fetch_response_enable, fresp_data,
    output mem_request_enable, mreq_mode,
    output mreq_addr, mreq_wdata, mreq_wstrb,
    input  mem_response_enable, mresp_data,
    input  request_enable, req_mode,
    input  req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/mem) arbiter with one outstanding MMU transaction.
// Define MEM_ARBITER_RR_EN for round-robin ties; default is fixed mem priority.
module mem_arbiter (
  input logic       clk,
  input logic       rst,
  mem_arbiter_if.slave bus
);

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } slot_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state;
  logic   owner;
  logic   f_pend;
  logic   m_pend;
  slot_t  f_slot;
  slot_t  m_slot;

  slot_t  f_in;
  slot_t  m_in;
  slot_t  f_cur;
  slot_t  m_cur;
  slot_t  grant;
  logic   f_take;
  logic   m_take;
  logic   f_elig;
  logic   m_elig;
  logic   pick_mem;

`ifdef MEM_ARBITER_RR_EN
  logic   last_mem;
`endif

  assign f_in = {bus.freq_mode, bus.freq_addr,
                 bus.freq_wdata, bus.freq_wstrb};
  assign m_in = {bus.mreq_mode, bus.mreq_addr,
                 bus.mreq_wdata, bus.mreq_wstrb};

  // pending stays set while in flight, so it also masks duplicate pulses
  always_comb begin
    f_take = bus.fetch_request_enable & ~f_pend;
    m_take = bus.mem_request_enable & ~m_pend;
    f_elig = f_pend | f_take;
    m_elig = m_pend | m_take;
    f_cur  = f_pend ? f_slot : f_in;
    m_cur  = m_pend ? m_slot : m_in;
`ifdef MEM_ARBITER_RR_EN
    pick_mem = m_elig & (~f_elig | ~last_mem);
`else
    pick_mem = m_elig;
`endif
    grant = pick_mem ? m_cur : f_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= S_IDLE;
      owner                     <= 1'b0;
      f_pend                    <= 1'b0;
      m_pend                    <= 1'b0;
      f_slot                    <= '0;
      m_slot                    <= '0;
      bus.request_enable        <= 1'b0;
      bus.req_mode              <= 1'b0;
      bus.req_addr              <= '0;
      bus.req_wdata             <= '0;
      bus.req_wstrb             <= '0;
      bus.fetch_response_enable <= 1'b0;
      bus.mem_response_enable   <= 1'b0;
      bus.fresp_data            <= '0;
      bus.mresp_data            <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_mem                  <= 1'b0;
`endif
    end else begin
      bus.request_enable        <= 1'b0;
      bus.fetch_response_enable <= 1'b0;
      bus.mem_response_enable   <= 1'b0;
      if (f_take) begin
        f_pend <= 1'b1;
        f_slot <= f_in;
      end
      if (m_take) begin
        m_pend <= 1'b1;
        m_slot <= m_in;
      end
      unique case (state)
        S_IDLE: begin
          if (f_elig | m_elig) begin
            state              <= S_WAIT;
            owner              <= pick_mem;
            bus.request_enable <= 1'b1;
            {bus.req_mode, bus.req_addr,
             bus.req_wdata, bus.req_wstrb} <= grant;
`ifdef MEM_ARBITER_RR_EN
            last_mem           <= pick_mem;
`endif
          end
        end
        S_WAIT: begin
          if (bus.response_enable) begin
            state <= S_IDLE;
            if (owner) begin
              m_pend                  <= 1'b0;
              bus.mresp_data          <= bus.resp_data;
              bus.mem_response_enable <= 1'b1;
            end else begin
              f_pend                    <= 1'b0;
              bus.fresp_data            <= bus.resp_data;
              bus.fetch_response_enable <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected downstream requests
// and upstream responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  typedef struct {
    int          cyc;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          cyc;
    logic        mem;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  logic prev_req;
  logic [31:0] last_f;
  logic [31:0] last_m;
  req_t  exp_req[$];
  resp_t exp_resp[$];
  req_t  rq;
  resp_t rs;
  int    b;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push_req(int c, logic m, logic [31:0] a,
                          logic [31:0] w, logic [3:0] s);
    req_t r;
    r.cyc = c; r.mode = m; r.addr = a; r.wdata = w; r.wstrb = s;
    exp_req.push_back(r);
  endtask

  task automatic push_resp(int c, logic m, logic [31:0] d);
    resp_t r;
    r.cyc = c; r.mem = m; r.data = d;
    exp_resp.push_back(r);
  endtask

  task automatic fetch_req(logic m, logic [31:0] a,
                           logic [31:0] w, logic [3:0] s);
    bus.fetch_request_enable = 1'b1;
    bus.freq_mode  = m;
    bus.freq_addr  = a;
    bus.freq_wdata = w;
    bus.freq_wstrb = s;
  endtask

  task automatic mem_req(logic m, logic [31:0] a,
                         logic [31:0] w, logic [3:0] s);
    bus.mem_request_enable = 1'b1;
    bus.mreq_mode  = m;
    bus.mreq_addr  = a;
    bus.mreq_wdata = w;
    bus.mreq_wstrb = s;
  endtask

  task automatic respond(logic [31:0] d);
    bus.response_enable = 1'b1;
    bus.resp_data       = d;
  endtask

  task automatic step();
    @(negedge clk);
    bus.fetch_request_enable = 1'b0;
    bus.mem_request_enable   = 1'b0;
    bus.response_enable      = 1'b0;
  endtask

  task automatic go_to(int t);
    while (cyc < t) step();
  endtask

  task automatic settle(int n);
    repeat (n) step();
    chk("req_queue_drained", exp_req.size(), 0);
    chk("resp_queue_drained", exp_resp.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last_f = '0;
    last_m = '0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_request_enable"}, bus.request_enable, 0);
    chk({tag, "_req_mode"}, bus.req_mode, 0);
    chk({tag, "_req_addr"}, bus.req_addr, 0);
    chk({tag, "_req_wdata"}, bus.req_wdata, 0);
    chk({tag, "_req_wstrb"}, bus.req_wstrb, 0);
    chk({tag, "_fetch_resp_en"}, bus.fetch_response_enable, 0);
    chk({tag, "_mem_resp_en"}, bus.mem_response_enable, 0);
    chk({tag, "_fresp_data"}, bus.fresp_data, 0);
    chk({tag, "_mresp_data"}, bus.mresp_data, 0);
  endtask

  // monitor: every DUT pulse must match the head of its queue
  initial prev_req = 1'b0;
  always @(negedge clk) begin
    if (bus.request_enable === 1'b1) begin
      chk("req_not_back_to_back", prev_req, 0);
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 1, 0);
      end else begin
        rq = exp_req.pop_front();
        chk("req_cycle", cyc, rq.cyc);
        chk("req_mode", bus.req_mode, rq.mode);
        chk("req_addr", bus.req_addr, rq.addr);
        chk("req_wdata", bus.req_wdata, rq.wdata);
        chk("req_wstrb", bus.req_wstrb, rq.wstrb);
      end
    end
    prev_req = bus.request_enable;
    if (bus.fetch_response_enable === 1'b1 ||
        bus.mem_response_enable === 1'b1) begin
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        rs = exp_resp.pop_front();
        chk("resp_cycle", cyc, rs.cyc);
        chk("resp_mem_pulse", bus.mem_response_enable, rs.mem);
        chk("resp_fetch_pulse", bus.fetch_response_enable, !rs.mem);
        if (rs.mem) begin
          chk("mresp_data", bus.mresp_data, rs.data);
          chk("fresp_hold", bus.fresp_data, last_f);
          last_m = rs.data;
        end else begin
          chk("fresp_data", bus.fresp_data, rs.data);
          chk("mresp_hold", bus.mresp_data, last_m);
          last_f = rs.data;
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.fetch_request_enable = 1'b0;
    bus.freq_mode  = 1'b0;
    bus.freq_addr  = '0;
    bus.freq_wdata = '0;
    bus.freq_wstrb = '0;
    bus.mem_request_enable = 1'b0;
    bus.mreq_mode  = 1'b0;
    bus.mreq_addr  = '0;
    bus.mreq_wdata = '0;
    bus.mreq_wstrb = '0;
    bus.response_enable = 1'b0;
    bus.resp_data  = '0;
    @(negedge clk);
    do_reset();
    chk_zero("reset");

    // fetch read
    b = cyc;
    fetch_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    push_req(b + 1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    step();
    go_to(b + 5);
    respond(32'hDEAD_BEEF);
    push_resp(b + 6, 1'b0, 32'hDEAD_BEEF);
    step();
    settle(4);

    // tie: mem wins, fetch follows two cycles after the response
    do_reset();
    b = cyc;
    fetch_req(1'b0, 32'h100, 32'h0, 4'h0);
    mem_req(1'b1, 32'h200, 32'h1234_5678, 4'hF);
    push_req(b + 1, 1'b1, 32'h200, 32'h1234_5678, 4'hF);
    push_req(b + 6, 1'b0, 32'h100, 32'h0, 4'h0);
    step();
    go_to(b + 4);
    respond(32'hA5A5_0001);
    push_resp(b + 5, 1'b1, 32'hA5A5_0001);
    step();
    go_to(b + 8);
    respond(32'h0000_0042);
    push_resp(b + 9, 1'b0, 32'h0000_0042);
    step();
    settle(4);

    // three consecutive ties, owner re-requests right after its response
    do_reset();
    b = cyc;
    fetch_req(1'b0, 32'h100, 32'h0, 4'h0);
    mem_req(1'b1, 32'h200, 32'h1111_1111, 4'hF);
    push_req(b + 1, 1'b1, 32'h200, 32'h1111_1111, 4'hF);
    step();
    go_to(b + 3);
    respond(32'hD000_0001);
    push_resp(b + 4, 1'b1, 32'hD000_0001);
    step();
    mem_req(1'b1, 32'h210, 32'h2222_2222, 4'h3);
`ifdef MEM_ARBITER_RR_EN
    push_req(b + 5, 1'b0, 32'h100, 32'h0, 4'h0);
    step();
    go_to(b + 7);
    respond(32'hD000_0002);
    push_resp(b + 8, 1'b0, 32'hD000_0002);
    step();
    fetch_req(1'b0, 32'h110, 32'h0, 4'h0);
    push_req(b + 9, 1'b1, 32'h210, 32'h2222_2222, 4'h3);
    step();
    go_to(b + 11);
    respond(32'hD000_0003);
    push_resp(b + 12, 1'b1, 32'hD000_0003);
    push_req(b + 13, 1'b0, 32'h110, 32'h0, 4'h0);
    step();
`else
    push_req(b + 5, 1'b1, 32'h210, 32'h2222_2222, 4'h3);
    step();
    go_to(b + 7);
    respond(32'hD000_0002);
    push_resp(b + 8, 1'b1, 32'hD000_0002);
    step();
    mem_req(1'b1, 32'h220, 32'h3333_3333, 4'hC);
    push_req(b + 9, 1'b1, 32'h220, 32'h3333_3333, 4'hC);
    step();
    go_to(b + 11);
    respond(32'hD000_0003);
    push_resp(b + 12, 1'b1, 32'hD000_0003);
    push_req(b + 13, 1'b0, 32'h100, 32'h0, 4'h0);
    step();
`endif
    go_to(b + 15);
    respond(32'hD000_0004);
    push_resp(b + 16, 1'b0, 32'hD000_0004);
    step();
    settle(4);

    // duplicate mem pulse while in flight is dropped
    do_reset();
    b = cyc;
    mem_req(1'b0, 32'h300, 32'h0, 4'h0);
    push_req(b + 1, 1'b0, 32'h300, 32'h0, 4'h0);
    step();
    go_to(b + 2);
    mem_req(1'b0, 32'h400, 32'h0, 4'h0);
    step();
    go_to(b + 4);
    respond(32'h0000_0033);
    push_resp(b + 5, 1'b1, 32'h0000_0033);
    step();
    settle(6);

    // reset mid-transaction abandons it; pulse during reset is dropped
    b = cyc;
    fetch_req(1'b0, 32'h500, 32'h0, 4'h0);
    push_req(b + 1, 1'b0, 32'h500, 32'h0, 4'h0);
    step();
    go_to(b + 3);
    rst = 1'b1;
    mem_req(1'b0, 32'h700, 32'h0, 4'h0);
    step();
    rst = 1'b0;
    last_f = '0;
    last_m = '0;
    chk_zero("midreset");
    go_to(b + 5);
    respond(32'hBAD0_0BAD);
    step();
    go_to(b + 7);
    fetch_req(1'b0, 32'h600, 32'h0, 4'h0);
    push_req(b + 8, 1'b0, 32'h600, 32'h0, 4'h0);
    step();
    go_to(b + 10);
    respond(32'h0000_0066);
    push_resp(b + 11, 1'b0, 32'h0000_0066);
    step();
    settle(4);

    // spurious response while idle
    respond(32'hFFFF_FFFF);
    step();
    settle(3);
    chk("spurious_fresp_hold", bus.fresp_data, last_f);
    chk("spurious_mresp_hold", bus.mresp_data, last_m);
    chk("spurious_fresp_value", bus.fresp_data, 32'h0000_0066);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
